addsub_pipe: RTL and testbench

Parametrised, pipelined integer add/subtract unit. Generalises the team's single-bit full subtractor cell into a WIDTH-bit datapath split into STAGES carry-registered chunks. Produces result plus N/Z/V/C flags with a valid/ready handshake and a flush input. Sits in the execute stage as the ALU's adder path and feeds the flags register.

---
 rtl/addsub_pkg.sv | 40 ++++
 rtl/addsub_if.sv | 29 ++
 rtl/addsub_chunk.sv | 36 +++
 rtl/addsub_pipe.sv | 161 ++++++++++++++++
 tb/tb_addsub_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types for the pipelined add/subtract unit.
// Op encoding, flag layout and configuration helpers.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  function automatic bit cfg_ok(int width, int stages);
    return (stages >= 1) && (stages <= 8) &&
           (width % stages == 0);
  endfunction

  // Bit offset of skew block k inside the packed
  // pending-operand vector (block k is W-(k+1)*CHUNK wide).
  function automatic int pend_off(int width, int stages,
                                  int k);
    int off;
    int chunk;
    off = 0;
    chunk = width / stages;
    for (int j = 0; j < k; j++)
      off += width - (j + 1) * chunk;
    return off;
  endfunction

endpackage

// File: rtl/addsub_if.sv
// addsub_if: operand/result handshake bundle.
// master drives operands, slave is the adder.
interface addsub_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  flags_t           flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit ripple slice.
// b is inverted when op selects subtract.
module addsub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb_in,
  output logic             zero
);

  logic [CHUNK:0] c;
  logic           bx;

  // Ripple carry across the slice, recording the carry
  // into the top bit for overflow detection.
  always_comb begin
    c    = '0;
    sum  = '0;
    bx   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      bx       = b[i] ^ op;
      sum[i]   = a[i] ^ bx ^ c[i];
      c[i + 1] = (a[i] & bx) | (c[i] & (a[i] ^ bx));
    end
    cout    = c[CHUNK];
    cmsb_in = c[CHUNK-1];
    zero    = ~|sum;
  end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit add/subtract with N/Z/V/C.
// One CHUNK per stage, carry and operands skewed stage to stage.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input logic     clk,
  input logic     reset,
  input logic     flush,
  addsub_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH/STAGES unsupported");
  end

  logic adv;

  // Per-stage state; acc holds finished low bits and
  // still-pending A bits above them.
  logic [LAST:0]            vld_q, vld_d;
  logic [LAST:0]            cy_q, cy_d;
  logic [LAST:0]            zr_q, zr_d;
  logic [LAST:0][WIDTH-1:0] acc_q, acc_d;
  logic                     v_q, v_d;

  // Stage inputs and chunk outputs.
  logic [LAST:0]            s_vld, s_op, s_cin, s_zin;
  logic [LAST:0][WIDTH-1:0] s_acc;
  logic [LAST:0][CHUNK-1:0] s_b, sum_w;
  logic [LAST:0]            cout_w, cmsb_w, zero_w;

  logic [3:0] fl;

  assign adv          = !vld_q[LAST] || bus.out_ready;
  assign bus.in_ready = adv;

  if (STAGES > 1) begin : g_skew
    localparam int PW = pend_off(WIDTH, STAGES, LAST);

    logic [PW-1:0]   pb_q, pb_d;
    logic [LAST-1:0] op_q, op_d;

    for (genvar k = 0; k < LAST; k++) begin : g_blk
      localparam int OFF = pend_off(WIDTH, STAGES, k);
      localparam int BW  = WIDTH - (k + 1) * CHUNK;

      logic [BW-1:0] src;

      if (k == 0) begin : g_src
        assign src = bus.b[WIDTH-1:CHUNK];
      end else begin : g_src
        assign src = pb_q[pend_off(WIDTH, STAGES, k - 1)
                          + CHUNK +: BW];
      end

      assign pb_d[OFF +: BW] = adv ? src : pb_q[OFF +: BW];
      assign op_d[k]         = adv ? s_op[k] : op_q[k];
    end

    // Skewed B slices and op follow the datapath stall.
    always_ff @(posedge clk) begin
      if (reset) begin
        pb_q <= '0;
        op_q <= '0;
      end else begin
        pb_q <= pb_d;
        op_q <= op_d;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_in
      assign s_vld[g] = bus.in_valid;
      assign s_op[g]  = bus.op;
      assign s_cin[g] = (bus.op == OP_SUB);
      assign s_zin[g] = 1'b1;
      assign s_acc[g] = bus.a;
      assign s_b[g]   = bus.b[CHUNK-1:0];
    end else begin : g_in
      assign s_vld[g] = vld_q[g-1];
      assign s_op[g]  = g_skew.op_q[g-1];
      assign s_cin[g] = cy_q[g-1];
      assign s_zin[g] = zr_q[g-1];
      assign s_acc[g] = acc_q[g-1];
      assign s_b[g]   = g_skew.pb_q[
        pend_off(WIDTH, STAGES, g - 1) +: CHUNK];
    end

    addsub_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a      (s_acc[g][g*CHUNK +: CHUNK]),
      .b      (s_b[g]),
      .op     (s_op[g]),
      .cin    (s_cin[g]),
      .sum    (sum_w[g]),
      .cout   (cout_w[g]),
      .cmsb_in(cmsb_w[g]),
      .zero   (zero_w[g])
    );
  end

  // All stages advance together on a free slot; flush only
  // drops valid bits so a same-cycle accept is lost too.
  always_comb begin
    vld_d = vld_q;
    cy_d  = cy_q;
    zr_d  = zr_q;
    acc_d = acc_q;
    v_d   = v_q;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_d[k]                    = s_vld[k];
        acc_d[k]                    = s_acc[k];
        acc_d[k][k*CHUNK +: CHUNK]  = sum_w[k];
        cy_d[k]                     = cout_w[k];
        zr_d[k]                     = s_zin[k] & zero_w[k];
      end
      v_d = cmsb_w[LAST] ^ cout_w[LAST];
    end
    if (flush) vld_d = '0;
  end

  // Pipeline registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      cy_q  <= '0;
      zr_q  <= '0;
      acc_q <= '0;
      v_q   <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      zr_q  <= zr_d;
      acc_q <= acc_d;
      v_q   <= v_d;
    end
  end

  // Flags are pure wiring from last-stage registers.
  always_comb begin
    fl         = '0;
    fl[FLAG_N] = acc_q[LAST][WIDTH-1];
    fl[FLAG_Z] = zr_q[LAST];
    fl[FLAG_V] = v_q;
    fl[FLAG_C] = cy_q[LAST];
  end

  assign bus.out_valid = vld_q[LAST];
  assign bus.result    = acc_q[LAST];
  assign bus.flags     = flags_t'(fl);

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe.
// Three builds: 64/4, 64/1 and 32/8.
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  addsub_if #(.WIDTH(64)) if4 ();
  addsub_if #(.WIDTH(64)) if1 ();
  addsub_if #(.WIDTH(32)) if8 ();

  addsub_pipe #(.WIDTH(64), .STAGES(4)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if4)
  );
  addsub_pipe #(.WIDTH(64), .STAGES(1)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if1)
  );
  addsub_pipe #(.WIDTH(32), .STAGES(8)) u_d8 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if8)
  );

  int vecs = 0;
  int errs = 0;
  logic [67:0] sb[$];

  function automatic logic [67:0] model(int w,
    logic [63:0] a, logic [63:0] b, logic op);
    logic [63:0] mask, ma, mb, r;
    logic [64:0] s;
    logic n, z, v, c;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ma = a & mask;
    mb = (op ? ~b : b) & mask;
    s = {1'b0, ma} + {1'b0, mb} + {64'd0, op};
    r = s[63:0] & mask;
    c = s[w];
    n = r[w-1];
    z = (r == 64'd0);
    v = (ma[w-1] == mb[w-1]) && (n != ma[w-1]);
    return {n, z, v, c, r};
  endfunction

  function automatic int lat_of(int sel);
    return (sel == 0) ? 4 : (sel == 1) ? 1 : 8;
  endfunction

  task automatic drive(int sel, logic v, logic o,
    logic [63:0] a, logic [63:0] b, logic ordy);
    case (sel)
      0: begin
        if4.in_valid = v; if4.op = o; if4.a = a;
        if4.b = b; if4.out_ready = ordy;
      end
      1: begin
        if1.in_valid = v; if1.op = o; if1.a = a;
        if1.b = b; if1.out_ready = ordy;
      end
      default: begin
        if8.in_valid = v; if8.op = o; if8.a = a[31:0];
        if8.b = b[31:0]; if8.out_ready = ordy;
      end
    endcase
  endtask

  task automatic sample(int sel, output logic ov,
    output logic ir, output logic [63:0] r,
    output logic [3:0] f);
    case (sel)
      0: begin
        ov = if4.out_valid; ir = if4.in_ready;
        r = if4.result; f = if4.flags;
      end
      1: begin
        ov = if1.out_valid; ir = if1.in_ready;
        r = if1.result; f = if1.flags;
      end
      default: begin
        ov = if8.out_valid; ir = if8.in_ready;
        r = {32'd0, if8.result}; f = if8.flags;
      end
    endcase
  endtask

  task automatic idle_all();
    for (int s = 0; s < 3; s++) drive(s, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    logic ov, ir;
    logic [63:0] r;
    logic [3:0] f;
    idle_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    sample(0, ov, ir, r, f);
    vecs++;
    if (ov !== 1'b0) begin
      errs++; $display("FAIL rst_ov: got %b want 0", ov);
    end
    vecs++;
    if (ir !== 1'b1) begin
      errs++; $display("FAIL rst_ir: got %b want 1", ir);
    end
    vecs++;
    if (r !== 64'd0) begin
      errs++; $display("FAIL rst_res: got %h want 0", r);
    end
    vecs++;
    if (f !== 4'b0000) begin
      errs++; $display("FAIL rst_flags: got %b want 0", f);
    end
  endtask

  task automatic test_single(string name, int sel,
    logic [63:0] a, logic [63:0] b, logic op,
    logic [63:0] er, logic [3:0] ef);
    logic ov, ir;
    logic [63:0] r;
    logic [3:0] f;
    logic [67:0] exp;
    int cyc;
    sb.delete();
    @(posedge clk);
    #1 drive(sel, 1, op, a, b, 1);
    sb.push_back(model(sel == 2 ? 32 : 64, a, b, op));
    @(negedge clk);
    sample(sel, ov, ir, r, f);
    vecs++;
    if (ir !== 1'b1) begin
      errs++; $display("FAIL %s_accept: got %b want 1",
                       name, ir);
    end
    @(posedge clk);
    #1 drive(sel, 0, 0, 0, 0, 1);
    cyc = 1;
    while (cyc <= 12) begin
      @(negedge clk);
      sample(sel, ov, ir, r, f);
      if (ov === 1'b1) break;
      cyc++;
      @(posedge clk);
      #1;
    end
    vecs++;
    if (cyc !== lat_of(sel)) begin
      errs++; $display("FAIL %s_latency: got %0d want %0d",
                       name, cyc, lat_of(sel));
    end
    vecs++;
    if (r !== er) begin
      errs++; $display("FAIL %s_res: got %h want %h",
                       name, r, er);
    end
    vecs++;
    if (f !== ef) begin
      errs++; $display("FAIL %s_flags: got %b want %b",
                       name, f, ef);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    vecs++;
    if ({f, r} !== exp) begin
      errs++; $display("FAIL %s_sb: got %h want %h",
                       name, {f, r}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ta[10], tb_v[10];
    logic to[10];
    logic ov, ir, ordy, stall_prev;
    logic [63:0] r, prev_r;
    logic [3:0] f, prev_f;
    logic [67:0] exp;
    int sent, got;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      ta[i] = {$urandom, $urandom};
      tb_v[i] = {$urandom, $urandom};
      to[i] = $urandom_range(0, 1) == 1;
    end
    ta[3] = tb_v[3];
    to[3] = 1'b1;
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    prev_r = '0;
    prev_f = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(posedge clk);
      #1;
      ordy = !(cyc >= 6 && cyc <= 8);
      if (sent < 10)
        drive(0, 1, to[sent], ta[sent], tb_v[sent], ordy);
      else
        drive(0, 0, 0, 0, 0, ordy);
      @(negedge clk);
      sample(0, ov, ir, r, f);
      vecs++;
      if (ir !== (!ov || ordy)) begin
        errs++; $display("FAIL b2b_ready c%0d: got %b ov %b",
                         cyc, ir, ov);
      end
      if (stall_prev) begin
        vecs++;
        if (ov !== 1'b1 || r !== prev_r || f !== prev_f) begin
          errs++; $display("FAIL b2b_hold c%0d: got %h/%b want %h/%b",
                           cyc, r, f, prev_r, prev_f);
        end
      end
      stall_prev = ov && !ordy;
      prev_r = r;
      prev_f = f;
      if (sent < 10 && ir) begin
        sb.push_back(model(64, ta[sent], tb_v[sent], to[sent]));
        sent++;
      end
      if (ov && ordy) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        vecs++;
        if ({f, r} !== exp) begin
          errs++; $display("FAIL b2b_res #%0d: got %h want %h",
                           got, {f, r}, exp);
        end
        got++;
      end
    end
    vecs++;
    if (got !== 10) begin
      errs++; $display("FAIL b2b_count: got %0d want 10", got);
    end
    @(posedge clk);
    #1 idle_all();
  endtask

  task automatic test_flush();
    logic ov, ir;
    logic [63:0] r;
    logic [3:0] f;
    logic [67:0] exp;
    sb.delete();
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk);
      #1;
      flush = (c == 3);
      if (c <= 3)
        drive(0, 1, 0, 64'(c + 1), 64'd2, 1);
      else if (c == 4)
        drive(0, 1, 1, 64'd100, 64'd1, 1);
      else
        drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      sample(0, ov, ir, r, f);
      if (c == 3 || c == 4) begin
        vecs++;
        if (ir !== 1'b1) begin
          errs++; $display("FAIL flush_ir c%0d: got %b want 1",
                           c, ir);
        end
      end
      if (c == 4) sb.push_back(model(64, 100, 1, 1));
      if ((c >= 1 && c <= 7) || c >= 9) begin
        vecs++;
        if (ov !== 1'b0) begin
          errs++; $display("FAIL flush_ov c%0d: got %b want 0",
                           c, ov);
        end
      end
      if (c == 8) begin
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        vecs++;
        if (ov !== 1'b1 || r !== 64'd99 || {f, r} !== exp) begin
          errs++; $display("FAIL flush_new: got %b %h want 1 %h",
                           ov, {f, r}, exp);
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_inflight();
    logic ov, ir;
    logic [63:0] r;
    logic [3:0] f;
    sb.delete();
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk);
      #1;
      reset = (c == 4);
      if (c <= 3)
        drive(0, 1, 0, 64'(c + 7), 64'd9, 1);
      else
        drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      sample(0, ov, ir, r, f);
      if (c == 4) begin
        vecs++;
        if (ov !== 1'b1) begin
          errs++; $display("FAIL rinf_pre_ov: got %b want 1", ov);
        end
      end
      if (c == 5) begin
        vecs++;
        if (r !== 64'd0 || f !== 4'd0 || ir !== 1'b1) begin
          errs++; $display("FAIL rinf_state: got %h %b %b want 0 0 1",
                           r, f, ir);
        end
      end
      if (c >= 5) begin
        vecs++;
        if (ov !== 1'b0) begin
          errs++; $display("FAIL rinf_ov c%0d: got %b want 0",
                           c, ov);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single("add53", 0, 64'd5, 64'd3, 0, 64'd8, 4'b0000);
    test_single("sub55", 0, 64'd5, 64'd5, 1, 64'd0, 4'b0101);
    test_single("sub01", 0, 64'd0, 64'd1, 1, '1, 4'b1000);
    test_single("addovf", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0,
                64'h8000_0000_0000_0000, 4'b1010);
    test_single("addwrap", 0, '1, 64'd1, 0, 64'd0, 4'b0101);
    test_back_to_back();
    test_flush();
    test_reset_inflight();
    test_single("s1_add53", 1, 64'd5, 64'd3, 0, 64'd8, 4'b0000);
    test_single("s1_addovf", 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0,
                64'h8000_0000_0000_0000, 4'b1010);
    test_single("s1_addwrap", 1, '1, 64'd1, 0, 64'd0, 4'b0101);
    test_single("w32_add53", 2, 64'd5, 64'd3, 0, 64'd8, 4'b0000);
    test_single("w32_addovf", 2, 64'h7FFF_FFFF, 64'd1, 0,
                64'h8000_0000, 4'b1010);
    test_single("w32_addwrap", 2, 64'hFFFF_FFFF, 64'd1, 0,
                64'd0, 4'b0101);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
